// File: rtl/display_bcd_mux.sv
// display_bcd_mux
//   Holds three BCD digits from the binary-to-BCD converter and scans them
//   onto a 3-digit common-anode 7-segment display, units first.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   load         single-cycle strobe, captures the three BCD inputs
//   bcd_centenas hundreds digit
//   bcd_dezenas  tens digit
//   bcd_unidades units digit
//   blank_en     1 = blank leading zeros (sampled every cycle)
//   seg[6:0]     segments, active-low, seg[0]=a .. seg[6]=g
//   an[2:0]      digit enables, active-low, an[0]=units .. an[2]=hundreds
//   frame_done   one-cycle pulse after each complete units/tens/hundreds scan
module display_bcd_mux #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] bcd_centenas,
  input  logic [3:0] bcd_dezenas,
  input  logic [3:0] bcd_unidades,
  input  logic       blank_en,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {UNI, DEZ, CEN} scan_t;

  scan_t         state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    h_c;
  logic [3:0]    h_d;
  logic [3:0]    h_u;
  logic [3:0]    digit;
  logic          blank;
  logic [2:0]    an_sel;
  logic [6:0]    seg_next;

  // Active-low gfedcba; non-BCD codes show a lone dash (segment g).
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign tick = (cnt == LAST);

  // Digit selection and leading-zero blanking for the current scan slot.
  // Units are never blanked so a value of zero still shows "0".
  always_comb begin
    digit  = h_u;
    an_sel = 3'b110;
    blank  = 1'b0;
    case (state)
      DEZ: begin
        digit  = h_d;
        an_sel = 3'b101;
        blank  = blank_en && (h_c == 4'd0) && (h_d == 4'd0);
      end
      CEN: begin
        digit  = h_c;
        an_sel = 3'b011;
        blank  = blank_en && (h_c == 4'd0);
      end
      default: begin
        digit  = h_u;
        an_sel = 3'b110;
        blank  = 1'b0;
      end
    endcase
  end

  assign seg_next = blank ? 7'b1111111 : bcd_to_seg(digit);

  // Stage boundary: held digits, prescaler, scan state and the output
  // register all update here; outputs are built from pre-edge state, so they
  // trail the scan state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_c        <= 4'd0;
      h_d        <= 4'd0;
      h_u        <= 4'd0;
      cnt        <= '0;
      state      <= UNI;
      seg        <= 7'b1111111;
      an         <= 3'b111;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        h_c <= bcd_centenas;
        h_d <= bcd_dezenas;
        h_u <= bcd_unidades;
      end
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        case (state)
          UNI:     state <= DEZ;
          DEZ:     state <= CEN;
          default: state <= UNI;
        endcase
      end
      seg        <= seg_next;
      an         <= blank ? 3'b111 : an_sel;
      frame_done <= tick && (state == CEN);
    end
  end

endmodule

// File: tb/tb_display_bcd_mux.sv
module tb_display_bcd_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] bcd_c, bcd_d, bcd_u;
  logic       blank_en;
  logic [6:0] seg4, seg1;
  logic [2:0] an4, an1;
  logic       fd4, fd1;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset for each instance, and held digits.
  int         n4, n1;
  logic [3:0] hc, hd, hu;
  logic [10:0] e4, e1;

  logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  display_bcd_mux #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_centenas(bcd_c),
    .bcd_dezenas(bcd_d), .bcd_unidades(bcd_u), .blank_en(blank_en),
    .seg(seg4), .an(an4), .frame_done(fd4));

  display_bcd_mux #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_centenas(bcd_c),
    .bcd_dezenas(bcd_d), .bcd_unidades(bcd_u), .blank_en(blank_en),
    .seg(seg1), .an(an1), .frame_done(fd1));

  // Expected {an, seg, frame_done} after the n-th running edge since reset.
  // The slot lit is the one active before that edge: each slot lasts div
  // edges, slots cycle units, tens, hundreds.
  function automatic logic [10:0] model_out(int n, int div, logic b,
                                            logic [3:0] c, logic [3:0] d, logic [3:0] u);
    int         slot;
    logic [3:0] dg;
    logic       blk;
    logic [2:0] a;
    logic [6:0] s;
    logic       f;
    slot = ((n - 1) / div) % 3;
    dg   = (slot == 0) ? u : (slot == 1) ? d : c;
    blk  = b && ((slot == 2 && c == 0) || (slot == 1 && c == 0 && d == 0));
    a    = blk ? 3'b111 : ~(3'b001 << slot);
    s    = blk ? 7'b1111111 : ((dg <= 4'd9) ? dec_tab[int'(dg)] : 7'b0111111);
    f    = ((n % div) == 0) && (slot == 2);
    return {a, s, f};
  endfunction

  // Drive one cycle of inputs, advance the reference, wait past the edge.
  task automatic step(input logic r, input logic l, input logic [3:0] c,
                      input logic [3:0] d, input logic [3:0] u, input logic b);
    rst_n = r; load = l; bcd_c = c; bcd_d = d; bcd_u = u; blank_en = b;
    if (!r) begin
      e4 = {3'b111, 7'b1111111, 1'b0};
      e1 = e4;
    end else begin
      n4++; n1++;
      e4 = model_out(n4, 4, b, hc, hd, hu);
      e1 = model_out(n1, 1, b, hc, hd, hu);
    end
    @(posedge clk); #1;
    if (!r) begin
      n4 = 0; n1 = 0; hc = 0; hd = 0; hu = 0;
    end else if (l) begin
      hc = c; hd = d; hu = u;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      checks++;
      if ({an4, seg4, fd4} !== 11'b111_1111111_0) begin
        errors++; $display("FAIL reset_div4 got %b want %b", {an4, seg4, fd4}, 11'b111_1111111_0);
      end
      checks++;
      if ({an1, seg1, fd1} !== 11'b111_1111111_0) begin
        errors++; $display("FAIL reset_div1 got %b want %b", {an1, seg1, fd1}, 11'b111_1111111_0);
      end
    end
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({an4, seg4, fd4} !== 11'b110_1000000_0) begin
      errors++; $display("FAIL first_edge got %b want %b", {an4, seg4, fd4}, 11'b110_1000000_0);
    end
  endtask

  task automatic test_load_255;
    int pulses = 0;
    step(1'b1, 1'b1, 4'd2, 4'd5, 4'd5, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      pulses += int'(fd4);
      checks++;
      if ({an4, seg4, fd4} !== e4) begin
        errors++; $display("FAIL load255_div4 got %b want %b", {an4, seg4, fd4}, e4);
      end
      checks++;
      if ({an1, seg1, fd1} !== e1) begin
        errors++; $display("FAIL load255_div1 got %b want %b", {an1, seg1, fd1}, e1);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL frame_pulses got %0d want 2", pulses);
    end
  endtask

  task automatic test_blanking;
    logic saw_units7 = 1'b0;
    step(1'b1, 1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
      if ({an4, seg4} === 10'b110_1111000) saw_units7 = 1'b1;
      checks++;
      if ({an4, seg4, fd4} !== e4) begin
        errors++; $display("FAIL blank007 got %b want %b", {an4, seg4, fd4}, e4);
      end
    end
    checks++;
    if (!saw_units7) begin
      errors++; $display("FAIL blank007_units got none want an=110 seg=1111000");
    end
    step(1'b1, 1'b1, 4'd0, 4'd4, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
      checks++;
      if ({an4, seg4, fd4} !== e4) begin
        errors++; $display("FAIL blank040_div4 got %b want %b", {an4, seg4, fd4}, e4);
      end
      checks++;
      if ({an1, seg1, fd1} !== e1) begin
        errors++; $display("FAIL blank040_div1 got %b want %b", {an1, seg1, fd1}, e1);
      end
    end
  endtask

  task automatic test_invalid;
    step(1'b1, 1'b1, 4'hC, 4'd1, 4'd9, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
      checks++;
      if ({an4, seg4, fd4} !== e4) begin
        errors++; $display("FAIL invalid_bcd got %b want %b", {an4, seg4, fd4}, e4);
      end
    end
  endtask

  task automatic test_coincident;
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({an1, seg1} !== 10'b101_0100100) begin
      errors++; $display("FAIL coincident got %b want %b", {an1, seg1}, 10'b101_0100100);
    end
    checks++;
    if ({an1, seg1, fd1} !== e1) begin
      errors++; $display("FAIL coincident_model got %b want %b", {an1, seg1, fd1}, e1);
    end
  endtask

  task automatic test_midscan_reset;
    int budget = 0;
    step(1'b1, 1'b1, 4'd8, 4'd6, 4'd3, 1'b0);
    while (an4 !== 3'b011 && budget < 20) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      budget++;
    end
    checks++;
    if (an4 !== 3'b011) begin
      errors++; $display("FAIL midscan_reach got an=%b want 011", an4);
    end
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    checks++;
    if ({an4, seg4, fd4} !== 11'b111_1111111_0) begin
      errors++; $display("FAIL midscan_reset got %b want %b", {an4, seg4, fd4}, 11'b111_1111111_0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      checks++;
      if ({an4, seg4, fd4} !== e4) begin
        errors++; $display("FAIL midscan_restart got %b want %b", {an4, seg4, fd4}, e4);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 5) == 0),
           4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      checks++;
      if ({an4, seg4, fd4} !== e4) begin
        errors++; $display("FAIL random_div4 got %b want %b", {an4, seg4, fd4}, e4);
      end
      checks++;
      if ({an1, seg1, fd1} !== e1) begin
        errors++; $display("FAIL random_div1 got %b want %b", {an1, seg1, fd1}, e1);
      end
    end
  endtask

  initial begin
    n4 = 0; n1 = 0; hc = 0; hd = 0; hu = 0;
    test_reset();
    test_load_255();
    test_blanking();
    test_invalid();
    test_coincident();
    test_midscan_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
